// File: rtl/expipe_pkg.sv
// Shared types for the execution-pipe load/store path: exception codes, satp modes
// and the payload/state types used by the address-translation stage.
package expipe_pkg;

    localparam int XLEN          = 64;
    localparam int SATP_MODE_LEN = 4;
    localparam int LDST_IDX_LEN  = 8;

    localparam logic [SATP_MODE_LEN-1:0] SATP_MODE_BARE = 4'd0;
    localparam logic [SATP_MODE_LEN-1:0] SATP_MODE_SV39 = 4'd8;

    typedef enum logic [1:0] {
        VADDER_NO_EXCEPT     = 2'd0,
        VADDER_ALIGN_EXCEPT  = 2'd1,
        VADDER_PAGE_EXCEPT   = 2'd2,
        VADDER_ACCESS_EXCEPT = 2'd3
    } except_code_t;

    // idx field width must match the stage's IDX_LEN parameter
    typedef struct packed {
        logic                     is_store;
        logic [XLEN-1:0]          vaddr;
        logic [LDST_IDX_LEN-1:0]  idx;
        except_code_t             except;
        logic [SATP_MODE_LEN-1:0] vm_mode;
    } xlate_entry_t;

    typedef enum logic [1:0] {
        IDLE,
        WAIT_RESP,
        FLUSH_DRAIN
    } xlate_state_t;

endpackage

// File: rtl/xlate_fifo.sv
// Generic power-of-two FIFO with synchronous flush; the head entry is visible
// combinationally and a count register separates full from empty.
module xlate_fifo #(
    parameter int  DEPTH = 2,
    parameter type T     = logic
) (
    input  logic clk_i,
    input  logic rst_n_i,
    input  logic flush_i,
    input  logic push_i,
    input  T     data_i,
    input  logic pop_i,
    output T     head_o,
    output logic full_o,
    output logic empty_o
);

    localparam int PW = $clog2(DEPTH);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [PW:0]   count;
    logic          push_ok;
    logic          pop_ok;

    assign full_o  = (count == (PW+1)'(DEPTH));
    assign empty_o = (count == '0);
    assign push_ok = push_i & ~full_o;
    assign pop_ok  = pop_i & ~empty_o;
    assign head_o  = mem[rd_ptr];

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (flush_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                mem[wr_ptr] <= data_i;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            if (push_ok && !pop_ok)      count <= count + 1'b1;
            else if (!push_ok && pop_ok) count <= count - 1'b1;
        end
    end

endmodule

// File: rtl/vaddr_xlate_stage.sv
// Virtual-to-physical translation stage between the address adder and the LSBs.
// Optional: LEN5_XLATE_BARE_BYPASS_EN lets BARE-mode entries skip the data TLB.
//   state       | meaning
//   IDLE        | serve FIFO head: bypass to output or issue TLB request
//   WAIT_RESP   | request accepted, waiting for / holding the TLB response
//   FLUSH_DRAIN | flushed with a request outstanding; swallow its response
module vaddr_xlate_stage
    import expipe_pkg::*;
#(
    parameter int IDX_LEN    = LDST_IDX_LEN,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                     clk_i,
    input  logic                     rst_n_i,
    input  logic                     flush_i,
    input  logic [SATP_MODE_LEN-1:0] vm_mode_i,
    input  logic                     vadd_valid_i,
    output logic                     vadd_ready_o,
    input  logic                     vadd_is_store_i,
    input  logic [XLEN-1:0]          vadd_vaddr_i,
    input  logic [IDX_LEN-1:0]       vadd_idx_i,
    input  except_code_t             vadd_except_i,
    output logic                     dtlb_valid_o,
    input  logic                     dtlb_ready_i,
    output logic [XLEN-1:0]          dtlb_vaddr_o,
    output logic                     dtlb_is_store_o,
    input  logic                     dtlb_valid_i,
    input  logic [XLEN-1:0]          dtlb_paddr_i,
    input  logic                     dtlb_pfault_i,
    input  logic                     dtlb_afault_i,
    output logic                     lsb_valid_o,
    input  logic                     lsb_ready_i,
    output logic                     lsb_is_store_o,
    output logic [IDX_LEN-1:0]       lsb_idx_o,
    output logic [XLEN-1:0]          lsb_paddr_o,
    output except_code_t             lsb_except_o
);

    xlate_state_t      state_q, state_d;
    xlate_entry_t      in_entry, head;
    logic              fifo_full, fifo_empty, pop;
    logic              out_free, head_bypass, dtlb_req, out_load;
    logic              resp_capture, resp_clear, outstanding;
    logic [XLEN-1:0]   out_paddr_d;
    except_code_t      out_except_d, tlb_except;

    logic              out_valid_q, out_is_store_q;
    logic [IDX_LEN-1:0] out_idx_q;
    logic [XLEN-1:0]   out_paddr_q;
    except_code_t      out_except_q;
    logic              resp_valid_q;
    logic [XLEN-1:0]   resp_paddr_q;
    except_code_t      resp_except_q;

    assign in_entry = '{is_store: vadd_is_store_i, vaddr: vadd_vaddr_i, idx: vadd_idx_i,
                        except: vadd_except_i, vm_mode: vm_mode_i};

    xlate_fifo #(
        .DEPTH (FIFO_DEPTH),
        .T     (xlate_entry_t)
    ) u_fifo (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .flush_i (flush_i),
        .push_i  (vadd_valid_i),
        .data_i  (in_entry),
        .pop_i   (pop),
        .head_o  (head),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign vadd_ready_o = ~fifo_full;
    assign out_free     = ~out_valid_q | lsb_ready_i;

`ifdef LEN5_XLATE_BARE_BYPASS_EN
    assign head_bypass = (head.except != VADDER_NO_EXCEPT) || (head.vm_mode == SATP_MODE_BARE);
`else
    assign head_bypass = (head.except != VADDER_NO_EXCEPT);
`endif

    // page fault wins over access fault
    assign tlb_except = dtlb_pfault_i ? VADDER_PAGE_EXCEPT :
                        dtlb_afault_i ? VADDER_ACCESS_EXCEPT : VADDER_NO_EXCEPT;

    always_comb begin
        state_d      = state_q;
        pop          = 1'b0;
        dtlb_req     = 1'b0;
        out_load     = 1'b0;
        out_paddr_d  = head.vaddr;
        out_except_d = head.except;
        resp_capture = 1'b0;
        resp_clear   = 1'b0;
        outstanding  = 1'b0;
        case (state_q)
            IDLE: begin
                if (!fifo_empty) begin
                    if (head_bypass) begin
                        if (out_free) begin
                            out_load = 1'b1;
                            pop      = 1'b1;
                        end
                    end else begin
                        dtlb_req = 1'b1;
                        if (dtlb_ready_i) state_d = WAIT_RESP;
                    end
                end
                outstanding = dtlb_req & dtlb_ready_i;
            end
            WAIT_RESP: begin
                if (resp_valid_q) begin
                    if (out_free) begin
                        out_load     = 1'b1;
                        out_paddr_d  = resp_paddr_q;
                        out_except_d = resp_except_q;
                        pop          = 1'b1;
                        resp_clear   = 1'b1;
                        state_d      = IDLE;
                    end
                end else if (dtlb_valid_i) begin
                    if (out_free) begin
                        out_load     = 1'b1;
                        out_paddr_d  = dtlb_paddr_i;
                        out_except_d = tlb_except;
                        pop          = 1'b1;
                        state_d      = IDLE;
                    end else begin
                        resp_capture = 1'b1;
                    end
                end
                outstanding = ~resp_valid_q & ~dtlb_valid_i;
            end
            FLUSH_DRAIN: begin
                if (dtlb_valid_i) state_d = IDLE;
                outstanding = ~dtlb_valid_i;
            end
            default: state_d = IDLE;
        endcase
        // a response that has already arrived (or arrives now) needs no draining
        if (flush_i) begin
            pop          = 1'b0;
            out_load     = 1'b0;
            resp_capture = 1'b0;
            state_d      = outstanding ? FLUSH_DRAIN : IDLE;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) state_q <= IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            out_valid_q    <= 1'b0;
            out_is_store_q <= 1'b0;
            out_idx_q      <= '0;
            out_paddr_q    <= '0;
            out_except_q   <= VADDER_NO_EXCEPT;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (out_load) begin
            out_valid_q    <= 1'b1;
            out_is_store_q <= head.is_store;
            out_idx_q      <= head.idx;
            out_paddr_q    <= out_paddr_d;
            out_except_q   <= out_except_d;
        end else if (lsb_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            resp_valid_q  <= 1'b0;
            resp_paddr_q  <= '0;
            resp_except_q <= VADDER_NO_EXCEPT;
        end else if (flush_i || resp_clear) begin
            resp_valid_q <= 1'b0;
        end else if (resp_capture) begin
            resp_valid_q  <= 1'b1;
            resp_paddr_q  <= dtlb_paddr_i;
            resp_except_q <= tlb_except;
        end
    end

    assign dtlb_valid_o    = dtlb_req;
    assign dtlb_vaddr_o    = head.vaddr;
    assign dtlb_is_store_o = head.is_store;
    assign lsb_valid_o     = out_valid_q;
    assign lsb_is_store_o  = out_is_store_q;
    assign lsb_idx_o       = out_idx_q;
    assign lsb_paddr_o     = out_paddr_q;
    assign lsb_except_o    = out_except_q;

endmodule
